pc_gen_ras: RTL

//  Fetch-stage program-counter generator: holds the PC register, computes next PC for

---
 rtl/pc_gen_ras.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pc_gen_ras.sv
// pc_gen_ras -- fetch-stage program-counter generator with a return-address stack.
//
// Holds the PC register and computes the next PC for the sequential, branch,
// jump, register-jump, call and return flows. Return targets are predicted
// from a circular return-address stack.
// Priority at each rising edge: rst > redirect > stall > npc_op.
//
// Ports:
//   clk          in   1      clock, all state updates on rising edge
//   rst          in   1      synchronous, active-high reset
//   stall        in   1      hold PC and RAS this cycle
//   redirect     in   1      later-stage correction, overrides stall and npc_op
//   redirect_pc  in   WIDTH  target used when redirect=1
//   npc_op       in   3      000 PLUS4, 001 BRANCH, 010 JUMP, 011 JR, 100 CALL, 101 RET
//   imm          in   26     [15:0] branch offset, [25:0] jump index
//   rs           in   WIDTH  register target for JR, fallback for RET on an empty stack
//   pc           out  WIDTH  current PC (registered)
//   npc          out  WIDTH  value PC takes at the next edge (combinational)
//   ras_count    out  CNT_W  number of valid RAS entries, 0..RAS_DEPTH
//   ras_ovf      out  1      one-cycle pulse: a CALL overwrote the oldest entry
//   ret_pred     out  1      last accepted RET took its target from the RAS
module pc_gen_ras #(
    parameter int unsigned     WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter int unsigned     CNT_W     = $clog2(RAS_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic [2:0]       npc_op,
    input  logic [25:0]      imm,
    input  logic [WIDTH-1:0] rs,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] npc,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_ovf,
    output logic             ret_pred
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

    typedef enum logic [2:0] {
        OP_PLUS4  = 3'b000,
        OP_BRANCH = 3'b001,
        OP_JUMP   = 3'b010,
        OP_JR     = 3'b011,
        OP_CALL   = 3'b100,
        OP_RET    = 3'b101
    } npc_op_e;

    logic [WIDTH-1:0] pc_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             retp_q, retp_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    npc_op_e          op;
    logic [WIDTH-1:0] pcplus4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] jump_tgt;
    logic [PTR_W-1:0] top_idx;
    logic             push;
    logic             stack_full;

    assign op         = npc_op_e'(npc_op);
    assign pcplus4    = pc_q + WIDTH'(4);
    assign br_off     = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
    // Upper bits above bit 27 come from pcplus4; the mask form stays legal at WIDTH=28.
    assign jump_tgt   = (pcplus4 & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({imm, 2'b00});
    // Power-of-two depth lets the pointer wrap naturally.
    assign top_idx    = ptr_q - PTR_W'(1);
    assign stack_full = (cnt_q == CNT_W'(RAS_DEPTH));

    always_comb begin
        npc    = pc_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        ovf_d  = 1'b0;
        retp_d = retp_q;
        push   = 1'b0;
        if (redirect) begin
            npc    = redirect_pc;
            retp_d = 1'b0;
        end else if (!stall) begin
            retp_d = 1'b0;
            case (op)
                OP_PLUS4:  npc = pcplus4;
                OP_BRANCH: npc = pcplus4 + br_off;
                OP_JUMP:   npc = jump_tgt;
                OP_JR:     npc = rs;
                OP_CALL: begin
                    npc   = jump_tgt;
                    push  = 1'b1;
                    ptr_d = ptr_q + PTR_W'(1);
                    // A full stack overwrites its oldest slot; the count saturates.
                    if (stack_full) ovf_d = 1'b1;
                    else            cnt_d = cnt_q + CNT_W'(1);
                end
                OP_RET: begin
                    if (cnt_q != '0) begin
                        npc    = ras_q[top_idx];
                        ptr_d  = top_idx;
                        cnt_d  = cnt_q - CNT_W'(1);
                        retp_d = 1'b1;
                    end else begin
                        npc = rs;
                    end
                end
                default:   npc = pcplus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            ptr_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            retp_q <= 1'b0;
        end else begin
            pc_q   <= npc;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            retp_q <= retp_d;
            if (push) ras_q[ptr_q] <= pcplus4;
        end
    end

    assign pc        = pc_q;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ret_pred  = retp_q;

endmodule
